gf32_reduce_acc: RTL and testbench
==================================

GF32_REDUCE_ACC -- requirements
Module: gf32_reduce_acc

Interface
REQ-001 Parameter POLY_LO, default 8'h8D, meaning low terms of modulus x^32+POLY_LO (default x^32+x^7+x^3+x^2+1); upper modulus bits are fixed at zero.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 p  input  63  carry-less 32x32 product from upstream multiplier (coefficient i = bit i).
REQ-005 p_valid  input  1  p is valid this cycle.
REQ-006 p_first  input  1  sideband qualified by p_valid; starts new accumulation.
REQ-007 p_ready  output  1  block accepts p this cycle.
REQ-008 r  output  32  reduced (optionally accumulated) GF(2^32) element.
REQ-009 r_valid  output  1  r is valid.
REQ-010 r_ready  input  1  downstream accepts r.

Function
REQ-011 Input handshake occurs when p_valid && p_ready; output handshake occurs when r_valid && r_ready.
REQ-012 Two-register pipeline: S1 (q, 38 bits, plus first flag) and S2 (r); latency from input handshake to r_valid is exactly 2 cycles when unstalled.
REQ-013 S1 load: q = {6'b0,p[31:0]} XOR clmul(p[62:32], POLY_LO); degree <= 37.
REQ-014 S2 load: red = q[31:0] XOR clmul(q[37:32], POLY_LO); degree <= 12, so no further fold.
REQ-015 All arithmetic is GF(2): XOR only, no carries.
REQ-016 S2 advances when S2 is empty or an output handshake occurs; S1 advances when S1 is empty or S2 advances.
REQ-017 p_ready = !s1_valid || s2_advance; combinational from r_ready; full throughput of 1/cycle with r_ready held high.
REQ-018 r and r_valid come directly from registers; r is held stable while r_valid && !r_ready.
REQ-019 Simultaneous input and output handshake in a full pipe: both stages shift, no bubble, no loss, order preserved.
REQ-020 Without acceptance (p_valid low) an advancing stage clears its valid; data registers need not change.

Reset
REQ-021 On rst_n low, immediately: S1/S2 valid flags 0, r = 0, accumulator = 0, r_valid = 0.
REQ-022 Reset mid-operation drops in-flight items; the first input after release is treated as p_first = 1.
REQ-023 p_ready is 1 one cycle after reset release at the latest.

Configuration
REQ-024 Macro GF32_ACC_EN defined: on S2 load, r = red if S1 first flag is set (or if this is the first load after reset), else r = red XOR previous r.
REQ-025 GF32_ACC_EN undefined: r = red; p_first is ignored; the port set is identical in both builds.

Structure
REQ-026 Package gf32_pkg holds: PROD_W = 63, FIELD_W = 32, FOLD1_W = 38, default POLY_LO constant, and the clmul function.
REQ-027 One combinational sub-module, gf32_fold, is parameterised on high-part width and is instantiated for both folds.

Verification
REQ-028 p = 63'h0000_0000_1234_5678 -> r = 32'h1234_5678, r_valid 2 cycles after acceptance.
REQ-029 p = 63'h1 << 32 -> r = 32'h0000_008D; p = 63'h1 << 62 -> r = 32'h4000_1037.
REQ-030 r_ready = 0 for 5 cycles, 3 items offered back-to-back -> 2 accepted, then p_ready = 0; r stable; all 3 delivered in order after r_ready = 1.
REQ-031 GF32_ACC_EN: (p_first = 1, p = 0x1234_5678) then (p_first = 0, p = 0x0000_FFFF) -> r = 0x1234_5678, then 0x1234_A987; without the macro -> 0x1234_5678, then 0x0000_FFFF.
REQ-032 rst_n pulsed low with both stages valid -> r_valid = 0 and r = 0 asynchronously; after release the next input emerges with no stale data.
REQ-033 Random soak of 10k products against a reference polynomial reducer, with random p_valid/r_ready stalls -> zero mismatches, no drops or duplicates.

Source files
------------

// File: rtl/gf32_pkg.sv
// rtl/gf32_pkg.sv - shared widths, default modulus low terms and carry-less multiply for the GF(2^32) reducer
package gf32_pkg;

  localparam int PROD_W  = 63;               // 32x32 carry-less product, degree <= 62
  localparam int FIELD_W = 32;               // GF(2^32) element width
  localparam int FOLD1_W = 38;               // after first fold, degree <= 37
  localparam int POLY_W  = 8;                // low terms of the modulus
  localparam int HI1_W   = PROD_W - FIELD_W;  // 31 high bits folded in stage 1
  localparam int HI2_W   = FOLD1_W - FIELD_W; // 6 high bits folded in stage 2

  // x^32 + x^7 + x^3 + x^2 + 1
  localparam logic [POLY_W-1:0] POLY_LO_DEFAULT = 8'h8D;

  // Carry-less product of a high part (up to 31 bits) with the modulus low terms
  function automatic logic [FOLD1_W-1:0] clmul(input logic [HI1_W-1:0] a,
                                               input logic [POLY_W-1:0] b);
    logic [FOLD1_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < HI1_W; i++) begin
      if (a[i]) begin
        acc = acc ^ ({{(FOLD1_W-POLY_W){1'b0}}, b} << i);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf32_fold.sv
// rtl/gf32_fold.sv - one fold step: lo XOR (hi * POLY_LO), using x^32 == POLY_LO
module gf32_fold import gf32_pkg::*; #(
  parameter int                HI_W    = HI1_W,
  parameter logic [POLY_W-1:0] POLY_LO = POLY_LO_DEFAULT
) (
  input  logic [FIELD_W-1:0] lo_i,
  input  logic [HI_W-1:0]    hi_i,
  output logic [FOLD1_W-1:0] fold_o
);

  // Pure XOR network; the high part is zero-extended to the clmul operand width
  assign fold_o = {{(FOLD1_W-FIELD_W){1'b0}}, lo_i} ^ clmul(HI1_W'(hi_i), POLY_LO);

endmodule

// File: rtl/gf32_reduce_acc.sv
// rtl/gf32_reduce_acc.sv - two-stage GF(2^32) reducer with optional XOR accumulation (macro GF32_ACC_EN)
module gf32_reduce_acc import gf32_pkg::*; #(
  parameter logic [POLY_W-1:0] POLY_LO = POLY_LO_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROD_W-1:0]  p,
  input  logic               p_valid,
  input  logic               p_first,
  output logic               p_ready,
  output logic [FIELD_W-1:0] r,
  output logic               r_valid,
  input  logic               r_ready
);

  logic               s1_valid_q, s1_valid_d;
  logic [FOLD1_W-1:0] q_q, q_d;
  logic               s2_valid_q, s2_valid_d;
  logic [FIELD_W-1:0] r_q, r_d;

  logic               s2_adv, s1_adv, in_hs, s2_load;
  logic [FOLD1_W-1:0] fold1_w, fold2_w;
  logic [FIELD_W-1:0] red;
  logic [HI2_W-1:0]   red_hi_unused;

  gf32_fold #(.HI_W(HI1_W), .POLY_LO(POLY_LO)) u_fold1 (
    .lo_i   (p[FIELD_W-1:0]),
    .hi_i   (p[PROD_W-1:FIELD_W]),
    .fold_o (fold1_w)
  );

  gf32_fold #(.HI_W(HI2_W), .POLY_LO(POLY_LO)) u_fold2 (
    .lo_i   (q_q[FIELD_W-1:0]),
    .hi_i   (q_q[FOLD1_W-1:FIELD_W]),
    .fold_o (fold2_w)
  );

  // Second fold has degree <= 12, so its top bits are always zero
  assign {red_hi_unused, red} = fold2_w;

  assign s2_adv  = !s2_valid_q || r_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign p_ready = s1_adv;
  assign in_hs   = p_valid && p_ready;
  assign s2_load = s2_adv && s1_valid_q;

  assign r       = r_q;
  assign r_valid = s2_valid_q;

`ifdef GF32_ACC_EN
  logic first_q, first_d;
  logic fresh_q, fresh_d;

  // S1 first flag travels with q; the first accepted item after reset always restarts the sum
  always_comb begin
    first_d = first_q;
    fresh_d = fresh_q;
    if (in_hs) begin
      first_d = p_first || fresh_q;
      fresh_d = 1'b0;
    end
  end

  // Accumulator flags, reset so the next accepted product starts a new sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      first_q <= first_d;
      fresh_q <= fresh_d;
    end
  end
`else
  logic p_first_unused;
  assign p_first_unused = p_first;
`endif

  // Pipeline next-state: stages shift on advance, data registers only load on real items
  always_comb begin
    s1_valid_d = s1_adv ? p_valid : s1_valid_q;
    q_d        = in_hs ? fold1_w : q_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    r_d        = r_q;
    if (s2_load) begin
`ifdef GF32_ACC_EN
      r_d = first_q ? red : (red ^ r_q);
`else
      r_d = red;
`endif
    end
  end

  // Stage registers; reset drops anything in flight and clears the accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      q_q        <= '0;
      s2_valid_q <= 1'b0;
      r_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      q_q        <= q_d;
      s2_valid_q <= s2_valid_d;
      r_q        <= r_d;
    end
  end

endmodule

// File: tb/tb_gf32_reduce_acc.sv
// tb/tb_gf32_reduce_acc.sv - randomized self-checking bench for gf32_reduce_acc against a polynomial-division model
module tb_gf32_reduce_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [62:0] p;
  logic        p_valid;
  logic        p_first;
  logic        p_ready;
  logic [31:0] r;
  logic        r_valid;
  logic        r_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_acc;
  bit          m_fresh;

  gf32_reduce_acc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p       (p),
    .p_valid (p_valid),
    .p_first (p_first),
    .p_ready (p_ready),
    .r       (r),
    .r_valid (r_valid),
    .r_ready (r_ready)
  );

  always #5 clk = ~clk;

  // Long division by x^32 + x^7 + x^3 + x^2 + 1
  function automatic logic [31:0] ref_reduce(input logic [62:0] v);
    logic [63:0] t;
    logic [63:0] m;
    t = {1'b0, v};
    m = 64'h0000_0001_0000_008D;
    for (int i = 62; i >= 32; i--) begin
      if (t[i]) t = t ^ (m << (i - 32));
    end
    return t[31:0];
  endfunction

  // Expected output for a product at the moment it is accepted
  function automatic logic [31:0] model_out(input logic [62:0] v, input bit first);
    logic [31:0] red;
    logic [31:0] res;
    red = ref_reduce(v);
`ifdef GF32_ACC_EN
    res = (first || m_fresh) ? red : (red ^ m_acc);
`else
    res = red;
`endif
    m_fresh = 1'b0;
    m_acc   = res;
    return res;
  endfunction

  function automatic logic [62:0] rand_p();
    return 63'({$urandom(), $urandom()});
  endfunction

  // Offer one product, wait for its result; lat counts cycles from the accepting cycle (-1 on timeout)
  task automatic send_one(input logic [62:0] pv, input bit first,
                          output logic [31:0] rv, output logic [31:0] ev, output int lat);
    @(negedge clk);
    p = pv; p_first = first; p_valid = 1'b1; r_ready = 1'b1;
    #1;
    for (int w = 0; w < 20 && !p_ready; w++) begin
      @(negedge clk);
      #1;
    end
    rv = '0; ev = '0;
    if (!p_ready) begin
      lat = -1;
      p_valid = 1'b0;
      return;
    end
    ev = model_out(pv, first);
    @(negedge clk);
    p_valid = 1'b0; p_first = 1'b0;
    lat = 1;
    #1;
    while (!r_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    rv = r;
    if (!r_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; p = '0; p_valid = 1'b0; p_first = 1'b0; r_ready = 1'b0;
    m_acc = '0; m_fresh = 1'b1;
    #1;
    checks++;
    if (r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid got %0b want 0", r_valid); end
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_r got %h want 00000000", r); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (p_ready !== 1'b1) begin errors++; $display("FAIL reset_p_ready got %0b want 1", p_ready); end
  endtask

  task automatic test_vectors();
    logic [62:0] vp [4];
    logic [31:0] vr [3];
    logic [31:0] rv, ev;
    int lat;
    vp[0] = 63'h0000_0000_1234_5678; vr[0] = 32'h1234_5678;
    vp[1] = 63'h1 << 32;             vr[1] = 32'h0000_008D;
    vp[2] = 63'h1 << 62;             vr[2] = 32'h4000_1037;
    vp[3] = '1;
    for (int i = 0; i < 4; i++) begin
      send_one(vp[i], 1'b1, rv, ev, lat);
      checks++;
      if (lat !== 2) begin errors++; $display("FAIL vec%0d_latency got %0d want 2", i, lat); end
      checks++;
      if (i < 3) begin
        if (rv !== vr[i]) begin errors++; $display("FAIL vec%0d_r got %h want %h", i, rv, vr[i]); end
      end else begin
        if (rv !== ev) begin errors++; $display("FAIL vec%0d_r got %h want %h", i, rv, ev); end
      end
    end
  endtask

  task automatic test_accumulate();
    logic [31:0] rv, ev, want2;
    int lat;
`ifdef GF32_ACC_EN
    want2 = 32'h1234_A987;
`else
    want2 = 32'h0000_FFFF;
`endif
    send_one(63'h1234_5678, 1'b1, rv, ev, lat);
    checks++;
    if (rv !== 32'h1234_5678) begin errors++; $display("FAIL acc_first got %h want 12345678", rv); end
    send_one(63'h0000_FFFF, 1'b0, rv, ev, lat);
    checks++;
    if (rv !== want2) begin errors++; $display("FAIL acc_second got %h want %h", rv, want2); end
  endtask

  task automatic test_stall();
    logic [62:0] items [3];
    logic [31:0] expq [$];
    logic [31:0] held, want;
    int n, got;
    for (int i = 0; i < 3; i++) items[i] = rand_p();
    n = 0; got = 0; held = '0;
    @(negedge clk);
    r_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      p_valid = (n < 3); p_first = 1'b1;
      if (n < 3) p = items[n];
      #1;
      if (c == 2) held = r;
      if (p_valid && p_ready) begin
        expq.push_back(model_out(items[n], 1'b1));
        n++;
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (n !== 2) begin errors++; $display("FAIL stall_accepted got %0d want 2", n); end
    checks++;
    if (p_ready !== 1'b0) begin errors++; $display("FAIL stall_p_ready got %0b want 0", p_ready); end
    want = (expq.size() > 0) ? expq[0] : 32'h0;
    checks++;
    if (r_valid !== 1'b1 || r !== want || r !== held) begin
      errors++; $display("FAIL stall_r_hold got %h/%0b (held %h) want %h/1", r, r_valid, held, want);
    end
    r_ready = 1'b1;
    for (int c = 0; c < 30 && got < 3; c++) begin
      p_valid = (n < 3);
      if (n < 3) p = items[n];
      #1;
      if (r_valid && r_ready) begin
        want = (expq.size() > 0) ? expq.pop_front() : 32'h0;
        checks++;
        if (r !== want) begin errors++; $display("FAIL stall_order%0d got %h want %h", got, r, want); end
        got++;
      end
      if (p_valid && p_ready) begin
        expq.push_back(model_out(items[n], 1'b1));
        n++;
      end
      @(negedge clk);
    end
    p_valid = 1'b0;
    checks++;
    if (got !== 3) begin errors++; $display("FAIL stall_delivered got %0d want 3", got); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rv, ev;
    int lat;
    bit extra;
    @(negedge clk);
    r_ready = 1'b0; p_first = 1'b1;
    for (int c = 0; c < 2; c++) begin
      p = rand_p(); p_valid = 1'b1;
      #1;
      if (p_ready) void'(model_out(p, 1'b1));
      @(negedge clk);
    end
    p_valid = 1'b0;
    #1;
    checks++;
    if (r_valid !== 1'b1 || p_ready !== 1'b0) begin
      errors++; $display("FAIL flight_full got r_valid %0b p_ready %0b want 1 0", r_valid, p_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (r_valid !== 1'b0 || r !== 32'h0) begin
      errors++; $display("FAIL flight_async_clear got %h/%0b want 00000000/0", r, r_valid);
    end
    m_acc = '0; m_fresh = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    send_one(rand_p(), 1'b0, rv, ev, lat);
    checks++;
    if (lat !== 2 || rv !== ev) begin
      errors++; $display("FAIL flight_after_reset got %h lat %0d want %h lat 2", rv, lat, ev);
    end
    extra = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (r_valid) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL flight_stale got extra output want none"); end
  endtask

  task automatic test_soak();
    localparam int N = 10000;
    logic [31:0] expq [$];
    logic [31:0] want;
    int sent, recv, cyc;
    bit dup;
    sent = 0; recv = 0; cyc = 0; dup = 1'b0;
    @(negedge clk);
    while ((sent < N || expq.size() > 0) && cyc < 80000) begin
      p_valid = (sent < N) && ($urandom_range(0, 3) != 0);
      p       = rand_p();
      p_first = ($urandom_range(0, 7) == 0);
      r_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (r_valid && r_ready) begin
        if (expq.size() == 0) begin
          dup = 1'b1;
        end else begin
          want = expq.pop_front();
          checks++;
          if (r !== want) begin errors++; $display("FAIL soak_item%0d got %h want %h", recv, r, want); end
        end
        recv++;
      end
      if (p_valid && p_ready) begin
        expq.push_back(model_out(p, p_first));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    p_valid = 1'b0; r_ready = 1'b1;
    checks++;
    if (recv !== N || dup) begin errors++; $display("FAIL soak_count got %0d dup %0b want %0d dup 0", recv, dup, N); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_accumulate();
    test_stall();
    test_reset_midflight();
    test_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
